// File: rtl/lemon_pkg.sv
// Shared constants for the register-file writeback scheduler.
package lemon_pkg;

    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned DATA_WIDTH = 64;

    // Grant bit positions in the two-way arbiter
    localparam int unsigned SRC_EXU = 0;
    localparam int unsigned SRC_LSU = 1;

    // Hard-wired zero register index
    localparam int unsigned X0_IDX = 0;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Issue, writeback-requester and register-file write-port signals of the scheduler.
interface regfile_wb_sched_if
    import lemon_pkg::*;
#(
    parameter int unsigned AW = ADDR_WIDTH,
    parameter int unsigned DW = DATA_WIDTH
);
    logic          iss_valid;
    logic          iss_wen;
    logic [AW-1:0] iss_rd;
    logic [AW-1:0] iss_rs1;
    logic [AW-1:0] iss_rs2;
    logic          iss_ready;

    logic          exu_valid;
    logic [AW-1:0] exu_rd;
    logic [DW-1:0] exu_data;
    logic          exu_ready;

    logic          lsu_valid;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          lsu_ready;

    logic          rf_wen;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_data;
    logic          wb_err;

    modport slave (
        input  iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
        output iss_ready,
        input  exu_valid, exu_rd, exu_data,
        output exu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        output rf_wen, rf_rd, rf_data, wb_err
    );

    modport master (
        output iss_valid, iss_wen, iss_rd, iss_rs1, iss_rs2,
        input  iss_ready,
        output exu_valid, exu_rd, exu_data,
        input  exu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        input  rf_wen, rf_rd, rf_data, wb_err
    );
endinterface

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-input round-robin arbiter; priority flips to the loser only on a conflict.
module rr_arb2
    import lemon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prio;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'(SRC_LSU);
        end else if (&req) begin
            prio <= ~prio;
        end
    end

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt       = '0;
            gnt[prio] = 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: busy-bit scoreboard, EXU/LSU arbitration, registered write.
module regfile_wb_sched
    import lemon_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = lemon_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = lemon_pkg::DATA_WIDTH
)(
    input logic              clk,
    input logic              rst,
    regfile_wb_sched_if.slave bus
);
    localparam int unsigned NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_nxt;
    logic [1:0]            gnt;
    logic                  acc_valid;
    logic [ADDR_WIDTH-1:0] acc_rd;
    logic [DATA_WIDTH-1:0] acc_data;
    logic                  haz;
    logic                  set_en;
    logic                  clr_en;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({bus.lsu_valid, bus.exu_valid}),
        .gnt (gnt)
    );

    // Hazard check sees only the busy bits registered at cycle start
    assign haz = busy[bus.iss_rs1] | busy[bus.iss_rs2] | (bus.iss_wen & busy[bus.iss_rd]);
    assign bus.iss_ready = ~haz;
    assign bus.exu_ready = gnt[SRC_EXU];
    assign bus.lsu_ready = gnt[SRC_LSU];

    assign acc_valid = |gnt;
    assign acc_rd    = gnt[SRC_LSU] ? bus.lsu_rd   : bus.exu_rd;
    assign acc_data  = gnt[SRC_LSU] ? bus.lsu_data : bus.exu_data;

    assign set_en = bus.iss_valid & ~haz & bus.iss_wen & (bus.iss_rd != ADDR_WIDTH'(X0_IDX));
    assign clr_en = acc_valid & (acc_rd != ADDR_WIDTH'(X0_IDX));

    // Clear is applied after set so a forced same-register collision resolves to free
    always_comb begin
        busy_nxt = busy;
        if (set_en) begin
            busy_nxt[bus.iss_rd] = 1'b1;
        end
        if (clr_en) begin
            busy_nxt[acc_rd] = 1'b0;
        end
        busy_nxt[X0_IDX] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            bus.rf_wen  <= 1'b0;
            bus.rf_rd   <= '0;
            bus.rf_data <= '0;
            bus.wb_err  <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            bus.rf_wen <= clr_en;
            if (clr_en) begin
                bus.rf_rd   <= acc_rd;
                bus.rf_data <= acc_data;
                if (!busy[acc_rd]) begin
                    bus.wb_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-port scheduler and scoreboard for the integer register file (`register_file`, single write port).
- Arbitrates two writeback requesters onto that one write port: EXU (ALU results) and LSU (load data).
- Keeps a busy bit per architectural register so the issue stage can stall on RAW and WAW hazards.
- Sits between issue, EXU/LSU and the register file's `wen/rd/dataD` inputs.

Parameters:
- ADDR_WIDTH, 5, register index width; the file has 1<<ADDR_WIDTH entries.
- DATA_WIDTH, 64, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- iss_valid  in  1  issue stage wants to dispatch an instruction.
- iss_wen  in  1  the issuing instruction writes a destination register.
- iss_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- iss_rs1  in  ADDR_WIDTH  source 1 of the issuing instruction.
- iss_rs2  in  ADDR_WIDTH  source 2 of the issuing instruction.
- iss_ready  out  1  dispatch allowed this cycle.
- exu_valid  in  1  EXU writeback request.
- exu_rd  in  ADDR_WIDTH  EXU destination register.
- exu_data  in  DATA_WIDTH  EXU result.
- exu_ready  out  1  EXU request accepted this cycle.
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  ADDR_WIDTH  LSU destination register.
- lsu_data  in  DATA_WIDTH  LSU load data.
- lsu_ready  out  1  LSU request accepted this cycle.
- rf_wen  out  1  register file write enable.
- rf_rd  out  ADDR_WIDTH  register file write address.
- rf_data  out  DATA_WIDTH  register file write data.
- wb_err  out  1  sticky error flag: writeback to a register that was not busy.

Behaviour:
- **Reset** (rst=1 at posedge):
  - all busy bits cleared; rf_wen=0, rf_rd=0, rf_data=0, wb_err=0; arbiter priority set to LSU.
  - Reset overrides every other event in the same cycle.
- **Scoreboard:** one busy bit per register. Register 0 is never busy and is never set.
- **Hazard check** (combinational):
  - haz = busy[iss_rs1] | busy[iss_rs2] | (iss_wen & busy[iss_rd]).
  - iss_ready = !haz. It is independent of iss_valid, so it may be asserted with iss_valid=0.
  - The check uses the busy bits registered at the start of the cycle. A register cleared this cycle becomes visible as free next cycle (one-cycle bubble, no bypass).
- **Issue:** on iss_valid & iss_ready & iss_wen & (iss_rd != 0), busy[iss_rd] is set at posedge.
- **Arbitration** (combinational grant, at most one acceptance per cycle):
  - Only EXU valid: EXU granted. Only LSU valid: LSU granted. Neither valid: no grant.
  - Both valid: the side holding priority is granted. Priority then flips to the loser, so a requester waiting through a conflict wins the next conflict.
  - Priority changes only on cycles where both are valid.
  - A requester must hold valid/rd/data stable until its ready is seen; unchanged requests are not dropped.
- **Writeback pipeline:**
  - The accepted request is registered. At the next posedge, rf_wen/rf_rd/rf_data present it: one-cycle latency, one write per cycle.
  - No acceptance: rf_wen=0 next cycle; rf_rd and rf_data hold their previous values.
  - Accepted request with rd=0: handshake completes, rf_wen stays 0, scoreboard untouched.
- **Busy clear:** busy[rd] is cleared at the same posedge that registers the accepted request. The register-file write lands one cycle later.
  - A dependent instruction can therefore issue in the cycle rf_wen=1. Because `register_file` reads are combinational from the array, the consumer reads on the cycle after that write. The issue stage guarantees the operand read happens no earlier than the cycle after dispatch.
- **Same-register set and clear in one cycle:** cannot occur, because issue to a busy rd is blocked. If it is forced (a protocol violation), the clear wins and wb_err is set.
- **Different-register set and clear in one cycle:** both take effect.
- **wb_err:** set when an accepted writeback has rd != 0 and busy[rd]=0. It stays set until rst.
- Only one outstanding write per register, enforced by the WAW stall.

Decomposition:
- Shared package `lemon_pkg`:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - Localparams SRC_EXU=0 and SRC_LSU=1 for grant encoding.
  - The x0 index constant.
- One sub-module, `rr_arb2`: two-input round-robin arbiter holding the priority flop, with inputs req[1:0] and outputs gnt[1:0].
- The scoreboard and writeback register stay in the top block.

Test Plan:
- Reset, then iss_valid=1, iss_wen=1, rd=5 with rs1=rs2=0 -> iss_ready=1 and busy[5] set. Next cycle, issue with rs1=5 -> iss_ready=0.
- EXU valid rd=5 data=0x1234 -> exu_ready=1 the same cycle; next cycle rf_wen=1, rf_rd=5, rf_data=0x1234. In that cycle, rs1=5 issue gets iss_ready=1.
- EXU rd=3 and LSU rd=4 both valid for 3 cycles, both busy -> LSU granted first, then EXU. rf writes appear as 4, then 3 on consecutive cycles.
- Writeback with rd=0, data=0xFFFF -> ready=1, rf_wen stays 0, wb_err=0.
- EXU writeback to rd=7 while busy[7]=0 -> rf_wen=1 next cycle and wb_err=1, which stays 1 until rst.
- rst asserted while busy[9]=1 and an LSU request pending -> next cycle all busy=0, rf_wen=0, wb_err=0, and the next conflict grants LSU.
